// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM encoding and line constants for transmitter and loader
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with push/pop/full/empty/count, active-low sync reset
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [7:0]  data_i,
  input  logic        pop_i,
  output logic [7:0]  data_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic push_ok, pop_ok;
  assign full_o = count_q == (AW+1)'(FIFO_DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign data_o = mem_q[rd_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok = pop_i && !empty_o;
  // pointer and occupancy update; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok) rd_q <= rd_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
  // storage is not reset; stale entries are unreachable once the pointers clear
  always_ff @(posedge clk) begin
    if (rst && push_ok) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for an even parity bit
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, head;
  logic tx_q, tx_d, pop, full, empty, bit_end;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(tx_valid),
    .data_i(tx_data),
    .pop_i(pop),
    .data_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(fifo_count)
  );
  assign tx_ready = !full;
  assign tx = tx_q;
  assign busy = (state_q != IDLE) || !empty;
  assign bit_end = cnt_q == CNT_MAX;
  // next state, baud count and line level; tx is precomputed for the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop = 1'b1;
          shift_d = head;
          state_d = START;
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d = '0;
      end
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        idx_d = idx_q + 1'b1;
`ifdef UART_TX_PARITY_EN
        if (idx_q == 3'(UART_DATA_BITS - 1)) state_d = PARITY;
`else
        if (idx_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) begin
        if (!empty) begin
          pop = 1'b1;
          shift_d = head;
          state_d = START;
        end else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_TX_PARITY_EN
    par_d = pop ? ^head : par_q;
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : UART_IDLE_LEVEL;
`else
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : UART_IDLE_LEVEL;
`endif
  end
  // FSM, counters and the registered line driver
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      tx_q <= UART_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
    end
  end
`ifdef UART_TX_PARITY_EN
  // parity of the byte in flight, captured when it leaves the FIFO
  always_ff @(posedge clk) begin
    if (!rst) par_q <= 1'b0;
    else par_q <= par_d;
  end
`endif
endmodule
